spi_txn_ctrl: RTL and testbench

SPI transaction controller that sequences the SCLK divider for one full-duplex, mode-3 transaction of WIDTH bits per request, toward the A2D/codec-control slaves. It owns SS_n, the MOSI/MISO shift register and the bit counter. It drives ld_SCLK to the divider and consumes the divider's shft and full strobes. It sits between the slider/volume readers and the divider; the wrapper spi_mstr_top instantiates this block and the divider.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_txn_ctrl.sv | 102 ++++++++++
 tb/tb_spi_txn_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: controller states, default word width
// and the SCLK divider reload value.
package spi_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} spi_state_t;

  localparam int         SPI_WIDTH   = 16;
  localparam logic [4:0] SCLK_LD_VAL = 5'b10111;

endpackage

// File: rtl/spi_txn_ctrl.sv
// Mode-3 SPI transaction sequencer: owns SS_n, the full-duplex shift register and
// the bit counter, and parks/releases the external SCLK divider via ld_SCLK.
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [WIDTH-1:0] cmd,
  input  logic             MISO,
  input  logic             SCLK_shft,
  input  logic             SCLK_full,
  output logic             ld_SCLK,
  output logic             SS_n,
  output logic             MOSI,
  output logic             done,
  output logic [WIDTH-1:0] rd_data
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ss_n_q, ss_n_d;
  logic             done_q, done_d;
  logic             ld_sclk_s;

  // State and datapath registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      ss_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      ss_n_q    <= ss_n_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; the terminating full strobe reloads the divider so SCLK never
  // takes a 17th fall (back porch).
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    ss_n_d    = ss_n_q;
    done_d    = 1'b0;
    ld_sclk_s = 1'b1;
    case (state_q)
      IDLE: begin
        if (wrt) begin
          shreg_d   = cmd;
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
          state_d   = SHIFT;
        end else begin
          ss_n_d    = 1'b1;
        end
      end
      SHIFT: begin
        ld_sclk_s = 1'b0;
        if (SCLK_full && (bit_cnt_q == CNT_LAST)) begin
          ld_sclk_s = 1'b1;
          ss_n_d    = 1'b1;
          done_d    = 1'b1;
          rd_data_d = shreg_q;
          state_d   = IDLE;
        end else if (SCLK_shft) begin
          shreg_d   = {shreg_q[WIDTH-2:0], MISO};
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else begin
          ss_n_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
      end
    endcase
  end

  assign ld_SCLK = ld_sclk_s;
  assign SS_n    = ss_n_q;
  assign MOSI    = shreg_q[WIDTH-1];
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: divider and mode-3 slave models around the DUT, random
// transactions scored against a transaction-level timing/data model.
module tb_spi_txn_ctrl;
  import spi_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 32 * W + 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wrt = 1'b0;
  logic [W-1:0] cmd = '0;
  logic         MISO, SCLK_shft, SCLK_full, ld_SCLK, SS_n, MOSI, done;
  logic [W-1:0] rd_data;

  spi_txn_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .MISO(MISO),
    .SCLK_shft(SCLK_shft), .SCLK_full(SCLK_full), .ld_SCLK(ld_SCLK),
    .SS_n(SS_n), .MOSI(MOSI), .done(done), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: reload 23 while ld_SCLK, else free-run; SCLK is the count MSB.
  logic [4:0] div_cnt;
  logic       sclk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)       div_cnt <= SCLK_LD_VAL;
    else if (ld_SCLK) div_cnt <= SCLK_LD_VAL;
    else              div_cnt <= div_cnt + 5'd1;
  assign sclk      = div_cnt[4];
  assign SCLK_shft = (div_cnt == 5'd17);
  assign SCLK_full = (div_cnt == 5'd31);

  // Mode-3 slave: drives MISO on SCLK falls, samples MOSI on rises.
  logic         loopback = 1'b1;
  logic [W-1:0] slave_word = '0, slave_tx_next = '0;
  logic [W-1:0] slave_sh, slave_rx;
  logic         slave_miso, sclk_prev, ss_prev;
  int           falls, rises;
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      slave_sh <= '0; slave_rx <= '0; slave_miso <= 1'b0;
      sclk_prev <= 1'b1; ss_prev <= 1'b1; falls <= 0; rises <= 0;
    end else begin
      sclk_prev <= sclk;
      ss_prev   <= SS_n;
      if (ss_prev && !SS_n) begin
        slave_sh <= slave_tx_next; slave_rx <= '0; falls <= 0; rises <= 0;
      end else if (!SS_n) begin
        if (sclk_prev && !sclk) begin
          slave_miso <= slave_sh[W-1];
          slave_sh   <= {slave_sh[W-2:0], 1'b0};
          falls      <= falls + 1;
        end else if (!sclk_prev && sclk) begin
          slave_rx <= {slave_rx[W-2:0], MOSI};
          rises    <= rises + 1;
        end
      end
    end
  assign MISO = loopback ? MOSI : slave_miso;

  typedef struct {
    logic [W-1:0] rd;
    logic [W-1:0] rx;
    int           due;
  } exp_t;
  exp_t sb[$];
  exp_t e_new, e;
  bit   active = 1'b0;
  int   acc = 0;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a request is accepted when the controller is free; it finishes LAT clks later.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb.delete();
      active = 1'b0;
    end else if (wrt && (!active || cyc >= acc + LAT)) begin
      acc           = cyc;
      active        = 1'b1;
      slave_tx_next = slave_word;
      e_new.rd      = loopback ? cmd : slave_word;
      e_new.rx      = cmd;
      e_new.due     = cyc + LAT;
      sb.push_back(e_new);
    end
  end

  // Monitor: per-cycle framing checks plus scoreboard pop on the expected done cycle.
  logic [W-1:0] model_rd = '0;
  bit           exp_ss_low, exp_ld, exp_done;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      model_rd = '0;
    end else begin
      exp_ss_low = active && (cyc >= acc + 1) && (cyc <= acc + LAT - 1);
      exp_ld     = !(active && (cyc >= acc + 1) && (cyc <= acc + LAT - 2));
      exp_done   = (sb.size() > 0) && (cyc == sb[0].due);
      chk("ss_n", SS_n, !exp_ss_low);
      chk("ld_sclk", ld_SCLK, exp_ld);
      chk("done", done, exp_done);
      if (SS_n) chk("sclk_high_when_deselected", sclk, 1);
      if (exp_done) begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e.rd);
        chk("slave_rx", slave_rx, e.rx);
        chk("sclk_falls", falls, W);
        chk("sclk_rises", rises, W);
        model_rd = e.rd;
      end
      chk("rd_data_hold", rd_data, model_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_txn(input logic [W-1:0] c, input logic [W-1:0] sw, input logic lb);
    @(negedge clk);
    loopback = lb; slave_word = sw; cmd = c; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0; cmd = W'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ss_n", SS_n, 1);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ld_sclk", ld_SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pulse_reset();

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("idle_mosi", MOSI, 0);
      chk("idle_sclk", sclk, 1);
    end

    // Loopback with stray wrt pulses at cycles 100 and 521.
    start_txn(16'hA5C3, W'($urandom), 1'b1);
    for (int i = 2; i <= 530; i++) begin
      @(negedge clk);
      wrt = (i == 100) || (i == 521);
      cmd = W'($urandom);
    end
    wrt = 1'b0;

    start_txn(16'h1234, 16'h0FF0, 1'b0);
    idle(530);

    // wrt held: back-to-back pair, cmd changing every cycle.
    @(negedge clk);
    loopback = 1'b0; slave_word = W'($urandom); cmd = W'($urandom); wrt = 1'b1;
    for (int i = 1; i <= 1040; i++) begin
      @(negedge clk);
      cmd = W'($urandom); slave_word = W'($urandom);
    end
    wrt = 1'b0;
    idle(20);

    // Abort mid-transaction, then a normal one.
    start_txn(W'($urandom), W'($urandom), 1'b0);
    idle(298);
    pulse_reset();
    idle(5);
    start_txn(W'($urandom), W'($urandom), 1'b0);
    idle(530);

    for (int t = 0; t < 3; t++) begin
      start_txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      idle(530 + $urandom_range(0, 3));
    end

    idle(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
